mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Shares one single-ported, fixed-latency unified memory between the 5-stage MIPS core's instruction-fetch (IF) port and data-memory (MEM-stage) port. Requests are arbitrated with data priority plus an anti-starvation limit for IF. Each transaction is issued to memory for one cycle, the response is captured after a fixed latency, and it is returned to the winning requester as a registered one-cycle pulse. The block sits between the core's IF/MEM stages and the memory model instantiated by the `cpu` top.

## Interface
- `MEM_LAT`, 1: cycles from `mem_en` to valid `mem_rdata` (legal 1..4).
- `STARVE_LIM`, 2: consecutive IF losses to data before IF is forced to win (legal 1..7).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  IF read request; held with `if_addr` stable until `if_ready`.
- `if_addr`  in  32  IF word address.
- `if_ready`  out  1  IF request accepted this cycle.
- `if_rvalid`  out  1  one-cycle IF response pulse.
- `if_rdata`  out  32  IF read data, valid with `if_rvalid`.
- `dm_req`  in  1  data request; held stable until `dm_ready`.
- `dm_we`  in  1  1 = write.
- `dm_wstrb`  in  4  byte enables for writes.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  write data.
- `dm_ready`  out  1  data request accepted this cycle.
- `dm_rvalid`  out  1  one-cycle data response pulse; also acknowledges writes.
- `dm_rdata`  out  32  read data; 0 for writes.
- `mem_en`  out  1  memory access strobe (one cycle per transaction).
- `mem_we`  out  4  byte write enables (0 for reads).
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid MEM_LAT cycles after `mem_en`.
- `busy`  out  1  transaction outstanding (state != IDLE).

## Operation
- FSM states: IDLE, WAIT.
- IDLE, no request: all strobes 0.
- IDLE with a request: grant one requester; assert its `*_ready` and `mem_en` combinationally in the same cycle; drive `mem_addr`/`mem_we`/`mem_wdata` from the winner. `mem_we` = `dm_wstrb` when `dm_we`, else 0. IF grants always drive `mem_we`=0. Latch the owner (IF/DM) and read/write flag. Load wait counter with MEM_LAT. Go to WAIT.
- Arbitration: data wins, unless `if_req` has lost to `dm_req` STARVE_LIM consecutive times; then IF wins.
- Starve counter: increments when both request and data wins; clears on any IF grant; saturates at STARVE_LIM.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture `mem_rdata` (or 0 for a write) into the owner's rdata register. Set the owner's rvalid for the next cycle and return to IDLE.
- In the rvalid cycle the FSM is IDLE and can grant a new request (rvalid and ready may coincide).
- Only one transaction is outstanding at a time. Requests arriving during WAIT receive no ready.
- `*_rdata` holds its last value between pulses.

## Timing
- Reset (async assert, sync to clk on release): state IDLE. Counters 0. All outputs 0, including both rdata registers and `busy`.
- Grant at cycle T. `mem_en` is high in T only. `mem_rdata` is sampled at the end of cycle T+MEM_LAT. `*_rvalid` is high in cycle T+MEM_LAT+1 only.
- `busy` is 1 in cycles T+1..T+MEM_LAT.
- Peak throughput: one transaction per MEM_LAT+1 cycles.
- Simultaneous `if_req` and `dm_req` at a grant: the starvation rule decides; the loser waits and keeps its request held.
- Reset asserted during WAIT: the transaction is dropped and no rvalid pulse follows reset release. A later grant behaves normally.
- A requester dropping its request before ready is legal and causes no grant.

## Test plan
- Reset: hold `rst_n`=0 with `if_req`=`dm_req`=1 → all outputs 0, no `mem_en`. Release → first grant is DM, on the first rising edge after release.
- IF read, MEM_LAT=1: `if_addr`=0xBFC00000, memory returns 0x3C1D0001 → `if_ready`+`mem_en` at T, `if_rvalid` at T+2 with `if_rdata`=0x3C1D0001, `dm_rvalid`=0.
- Simultaneous requests: `if_addr`=0x100, `dm_addr`=0x2000 → DM granted at T. IF granted at T+2 (coinciding with `dm_rvalid`). `if_rvalid` at T+4.
- Starvation, STARVE_LIM=2, both requesting continuously → grant order DM, DM, IF, DM, DM, IF at cycles T, T+2, T+4, …
- Write: `dm_we`=1, `dm_wstrb`=0011, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF → `mem_we`=0011 and `mem_wdata`=0xDEADBEEF at T. `dm_rvalid` at T+MEM_LAT+1 with `dm_rdata`=0.
- MEM_LAT=3 with reset mid-WAIT: grant at T, `rst_n` low at T+2 for 1 cycle → no rvalid ever for that transaction. `busy`=0 immediately on reset.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one fixed-latency memory between the IF and MEM-stage ports
module mips_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_wstrb,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, starve_q, starve_d;
  logic        own_dm_q, own_dm_d, wr_q, wr_d;
  logic        if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        idle, starved, grant_if, grant_dm;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = state_q == WAIT;
  // Arbitration, memory strobes, wait countdown and response capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    own_dm_d    = own_dm_q;
    wr_d        = wr_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    starved     = starve_q >= 3'(STARVE_LIM);
    idle        = rst_n && state_q == IDLE;
    grant_if    = idle && if_req && (!dm_req || starved);
    grant_dm    = idle && dm_req && !grant_if;
    if_ready    = grant_if;
    dm_ready    = grant_dm;
    mem_en      = grant_if || grant_dm;
    mem_we      = (grant_dm && dm_we) ? dm_wstrb : 4'b0;
    mem_addr    = grant_dm ? dm_addr : grant_if ? if_addr : 32'b0;
    mem_wdata   = grant_dm ? dm_wdata : 32'b0;
    if (mem_en) begin
      state_d  = WAIT;
      cnt_d    = 3'(MEM_LAT);
      own_dm_d = grant_dm;
      wr_d     = grant_dm && dm_we;
      starve_d = grant_if ? 3'd0 : (if_req && !starved) ? starve_q + 3'd1 : starve_q;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = IDLE;
        if (own_dm_q) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = wr_q ? 32'b0 : mem_rdata;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
    end
  end
  // State and response registers; reset drops any outstanding transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 3'd0;
      own_dm_q    <= 1'b0;
      wr_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'b0;
      dm_rdata_q  <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      own_dm_q    <= own_dm_d;
      wr_q        <= wr_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed vectors for the IF/data memory arbiter at latencies 1 and 3
module tb_mips_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n = 1'b0, rst3_n = 1'b0;
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [3:0]  dm_wstrb = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic        if_ready, if_rvalid, dm_ready, dm_rvalid, mem_en, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        i3_req = 0, d3_req = 0, d3_we = 0;
  logic [3:0]  d3_wstrb = 0;
  logic [31:0] i3_addr = 0, d3_addr = 0, d3_wdata = 0;
  logic        if_ready3, if_rvalid3, dm_ready3, dm_rvalid3, mem_en3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_we3;
  int n_chk = 0, n_fail = 0;

  mips_mem_arbiter #(.MEM_LAT(1), .STARVE_LIM(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we),
    .dm_wstrb(dm_wstrb), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mips_mem_arbiter #(.MEM_LAT(3), .STARVE_LIM(2)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .if_req(i3_req), .if_addr(i3_addr), .if_ready(if_ready3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .dm_req(d3_req), .dm_we(d3_we),
    .dm_wstrb(d3_wstrb), .dm_addr(d3_addr), .dm_wdata(d3_wdata), .dm_ready(dm_ready3),
    .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'hBFC00000 ? 32'h3C1D0001 : a ^ 32'h5A5A5A5A;
  endfunction

  // Memory models: data is only valid in the exact cycle MEM_LAT after mem_en
  logic [2:0]  m1_cnt = 0, m3_cnt = 0;
  logic [31:0] m1_addr = 0, m3_addr = 0;
  assign mem_rdata  = (m1_cnt == 3'd1) ? mem_f(m1_addr) : 32'hBAD0BAD0;
  assign mem_rdata3 = (m3_cnt == 3'd1) ? mem_f(m3_addr) : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_en) begin m1_cnt <= 3'd1; m1_addr <= mem_addr; end
    else if (m1_cnt != 0) m1_cnt <= m1_cnt - 3'd1;
    if (mem_en3) begin m3_cnt <= 3'd3; m3_addr <= mem_addr3; end
    else if (m3_cnt != 0) m3_cnt <= m3_cnt - 3'd1;
  end

  typedef struct {
    logic ir; logic [31:0] ia; logic dr, dw; logic [3:0] ds; logic [31:0] da, dd;
    logic e_ir, e_dr, e_en; logic [3:0] e_we; logic [31:0] e_addr, e_wd;
    logic e_iv; logic [31:0] e_ird; logic e_dv; logic [31:0] e_drd; logic e_busy;
  } vec_t;
  vec_t v[22];

  localparam logic [31:0] RA = 32'h5A5A7A5A, RB = 32'h5A5A5B5A, BF = 32'h3C1D0001;
  localparam logic [31:0] R4 = 32'h5A5A5E5A, R3 = 32'h5A5A595A;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0]  = '{1, 32'h100, 1, 0, 4'h0, 32'h2000, 0,   0, 1, 1, 4'h0, 32'h2000, 0,            0, 0,  0, 0,  0};
    v[1]  = '{1, 32'h100, 0, 0, 4'h0, 0, 0,          0, 0, 0, 4'h0, 0, 0,                   0, 0,  0, 0,  1};
    v[2]  = '{1, 32'h100, 0, 0, 4'h0, 0, 0,          1, 0, 1, 4'h0, 32'h100, 0,             0, 0,  1, RA, 0};
    v[3]  = '{0, 0, 0, 0, 4'h0, 0, 0,                0, 0, 0, 4'h0, 0, 0,                   0, 0,  0, RA, 1};
    v[4]  = '{1, 32'hBFC00000, 0, 0, 4'h0, 0, 0,     1, 0, 1, 4'h0, 32'hBFC00000, 0,        1, RB, 0, RA, 0};
    v[5]  = '{0, 0, 0, 0, 4'h0, 0, 0,                0, 0, 0, 4'h0, 0, 0,                   0, RB, 0, RA, 1};
    v[6]  = '{0, 0, 1, 1, 4'h3, 32'h40, 32'hDEADBEEF, 0, 1, 1, 4'h3, 32'h40, 32'hDEADBEEF,  1, BF, 0, RA, 0};
    v[7]  = '{0, 0, 0, 0, 4'h0, 0, 0,                0, 0, 0, 4'h0, 0, 0,                   0, BF, 0, RA, 1};
    v[8]  = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 1, 1, 4'h0, 32'h400, 0,             0, BF, 1, 0,  0};
    v[9]  = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 0, 0, 4'h0, 0, 0,                   0, BF, 0, 0,  1};
    v[10] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 1, 1, 4'h0, 32'h400, 0,             0, BF, 1, R4, 0};
    v[11] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 0, 0, 4'h0, 0, 0,                   0, BF, 0, R4, 1};
    v[12] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    1, 0, 1, 4'h0, 32'h300, 0,             0, BF, 1, R4, 0};
    v[13] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 0, 0, 4'h0, 0, 0,                   0, BF, 0, R4, 1};
    v[14] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 1, 1, 4'h0, 32'h400, 0,             1, R3, 0, R4, 0};
    v[15] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 0, 0, 4'h0, 0, 0,                   0, R3, 0, R4, 1};
    v[16] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 1, 1, 4'h0, 32'h400, 0,             0, R3, 1, R4, 0};
    v[17] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    0, 0, 0, 4'h0, 0, 0,                   0, R3, 0, R4, 1};
    v[18] = '{1, 32'h300, 1, 0, 4'h0, 32'h400, 0,    1, 0, 1, 4'h0, 32'h300, 0,             0, R3, 1, R4, 0};
    v[19] = '{0, 0, 1, 0, 4'h0, 32'h400, 0,          0, 0, 0, 4'h0, 0, 0,                   0, R3, 0, R4, 1};
    v[20] = '{0, 0, 0, 0, 4'h0, 0, 0,                0, 0, 0, 4'h0, 0, 0,                   1, R3, 0, R4, 0};
    v[21] = '{0, 0, 0, 0, 4'h0, 0, 0,                0, 0, 0, 4'h0, 0, 0,                   0, R3, 0, R4, 0};

    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_addr = 32'h2000;
    i3_req = 1; d3_req = 1; d3_addr = 32'h80;
    repeat (2) @(posedge clk);
    #5;
    chk("rst if_ready", if_ready, 0);
    chk("rst dm_ready", dm_ready, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst if_rvalid", if_rvalid, 0);
    chk("rst dm_rvalid", dm_rvalid, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    chk("rst3 ready", {if_ready3, dm_ready3, mem_en3, busy3}, 0);
    nxt();
    rst_n = 1; i3_req = 0; d3_req = 0;
    for (int i = 0; i < 22; i++) begin
      if_req = v[i].ir; if_addr = v[i].ia; dm_req = v[i].dr; dm_we = v[i].dw;
      dm_wstrb = v[i].ds; dm_addr = v[i].da; dm_wdata = v[i].dd;
      #4;
      chk($sformatf("r%0d if_ready", i), if_ready, v[i].e_ir);
      chk($sformatf("r%0d dm_ready", i), dm_ready, v[i].e_dr);
      chk($sformatf("r%0d mem_en", i), mem_en, v[i].e_en);
      chk($sformatf("r%0d mem_we", i), mem_we, v[i].e_we);
      chk($sformatf("r%0d mem_addr", i), mem_addr, v[i].e_addr);
      chk($sformatf("r%0d mem_wdata", i), mem_wdata, v[i].e_wd);
      chk($sformatf("r%0d if_rvalid", i), if_rvalid, v[i].e_iv);
      chk($sformatf("r%0d if_rdata", i), if_rdata, v[i].e_ird);
      chk($sformatf("r%0d dm_rvalid", i), dm_rvalid, v[i].e_dv);
      chk($sformatf("r%0d dm_rdata", i), dm_rdata, v[i].e_drd);
      chk($sformatf("r%0d busy", i), busy, v[i].e_busy);
      nxt();
    end

    rst3_n = 1;
    nxt();
    d3_req = 1; d3_addr = 32'h80;
    #4;
    chk("l3 dm_ready", dm_ready3, 1);
    chk("l3 mem_en", mem_en3, 1);
    chk("l3 mem_addr", mem_addr3, 32'h80);
    nxt();
    d3_req = 0;
    #4;
    chk("l3 busy t1", busy3, 1);
    nxt();
    #4;
    chk("l3 busy t2", busy3, 1);
    chk("l3 rvalid t2", dm_rvalid3, 0);
    nxt();
    #4;
    chk("l3 busy t3", busy3, 1);
    chk("l3 rvalid t3", dm_rvalid3, 0);
    nxt();
    #4;
    chk("l3 rvalid t4", dm_rvalid3, 1);
    chk("l3 rdata t4", dm_rdata3, 32'h5A5A5ADA);
    chk("l3 busy t4", busy3, 0);
    nxt();
    #4;
    chk("l3 rvalid t5", dm_rvalid3, 0);
    chk("l3 rdata hold", dm_rdata3, 32'h5A5A5ADA);
    nxt();
    d3_req = 1; d3_addr = 32'h90;
    #4;
    chk("l3r dm_ready", dm_ready3, 1);
    nxt();
    d3_req = 0;
    #4;
    chk("l3r busy t1", busy3, 1);
    nxt();
    rst3_n = 0;
    #1;
    chk("l3r busy in reset", busy3, 0);
    chk("l3r rdata in reset", dm_rdata3, 0);
    chk("l3r rvalid in reset", dm_rvalid3, 0);
    nxt();
    rst3_n = 1;
    for (int k = 0; k < 6; k++) begin
      #4;
      chk($sformatf("l3r no rvalid %0d", k), dm_rvalid3, 0);
      chk($sformatf("l3r idle %0d", k), busy3, 0);
      nxt();
    end
    d3_req = 1; d3_addr = 32'hA0;
    #4;
    chk("l3n dm_ready", dm_ready3, 1);
    chk("l3n mem_addr", mem_addr3, 32'hA0);
    nxt();
    d3_req = 0;
    repeat (3) nxt();
    #4;
    chk("l3n rvalid", dm_rvalid3, 1);
    chk("l3n rdata", dm_rdata3, 32'h5A5A5AFA);
    nxt();
    #4;
    chk("l3n rvalid end", dm_rvalid3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
